// File: rtl/cordic_pipe_stage.sv
// -----------------------------------------------------------------------------
// cordic_pipe_stage
//
// One registered micro-rotation of a pipelined CORDIC rotator. The direction of
// rotation follows the sign of the incoming phase residual Z (zero rotates in
// the positive direction). X and Y are updated with arithmetically shifted
// cross-terms, and the stage's arctangent constant is removed from Z:
//
//   z >= 0 : x' = x - (y >>> shift), y' = y + (x >>> shift), z' = z - constant
//   z <  0 : x' = x + (y >>> shift), y' = y - (x >>> shift), z' = z + constant
//
// All arithmetic wraps: modulo 2^bitwidth for X/Y and 2^zwidth for Z. There is
// no saturation, no overflow flag and no gain compensation. The parent chain
// provides the headroom and absorbs the ~1.647 CORDIC gain.
//
// Latency is exactly one clock. A new sample is accepted every clock, and there
// is no handshake. The outputs come straight from registers.
//
// Parameters:
//   bitwidth : X/Y datapath width (two's complement)
//   zwidth   : phase residual width (two's complement)
//   shift    : stage index k, the arithmetic right shift of the cross-terms,
//              legal range 0 .. bitwidth-1
//
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous, active-high; clears xo/yo/zo
//   xi, yi   : X/Y in, bitwidth bits, two's complement
//   zi       : phase residual in, zwidth bits, two's complement
//   constant : arctangent constant for this stage, zwidth bits, unsigned
//   xo, yo   : registered X/Y out
//   zo       : registered phase residual out
//
// Build option:
//   CORDIC_STAGE_ROUND_EN : when defined and shift > 0, the shifted cross-terms
//                           are rounded half-up instead of truncated (floor).
//                           The default build leaves it undefined and truncates.
// -----------------------------------------------------------------------------
module cordic_pipe_stage #(
    parameter int bitwidth = 18,
    parameter int zwidth   = 15,
    parameter int shift    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [bitwidth-1:0] xi,
    input  logic [bitwidth-1:0] yi,
    input  logic [zwidth-1:0]   zi,
    input  logic [zwidth-1:0]   constant,
    output logic [bitwidth-1:0] xo,
    output logic [bitwidth-1:0] yo,
    output logic [zwidth-1:0]   zo
);

    // -------------------------------------------------------------------------
    // Shifted cross-terms
    // -------------------------------------------------------------------------
    logic [bitwidth-1:0] xs;
    logic [bitwidth-1:0] ys;

    generate
        if (shift == 0) begin : g_no_shift
            // With no shift the cross-terms are the raw inputs in both builds.
            // This also avoids referencing bit index -1 in the rounding path.
            assign xs = xi;
            assign ys = yi;
        end else begin : g_shift
            logic [bitwidth-1:0] xs_floor;
            logic [bitwidth-1:0] ys_floor;

            // Arithmetic shift replicates the sign bit and discards the low
            // bits, which gives floor(v / 2^shift).
            assign xs_floor = $unsigned($signed(xi) >>> shift);
            assign ys_floor = $unsigned($signed(yi) >>> shift);

`ifdef CORDIC_STAGE_ROUND_EN
            // Half-up rounding adds back the most significant discarded bit.
            // The sum wraps within bitwidth like the rest of the datapath.
            assign xs = xs_floor + {{(bitwidth-1){1'b0}}, xi[shift-1]};
            assign ys = ys_floor + {{(bitwidth-1){1'b0}}, yi[shift-1]};
`else
            assign xs = xs_floor;
            assign ys = ys_floor;
`endif
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Rotation direction and next-state datapath
    // -------------------------------------------------------------------------
    logic                z_is_pos;
    logic [bitwidth-1:0] x_d;
    logic [bitwidth-1:0] y_d;
    logic [zwidth-1:0]   z_d;

    // Zero counts as positive, so only the sign bit matters.
    assign z_is_pos = ~zi[zwidth-1];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        x_d = xi;
        y_d = yi;
        z_d = zi;
        if (z_is_pos) begin
            x_d = xi - ys;
            y_d = yi + xs;
            z_d = zi - constant;
        end else begin
            x_d = xi + ys;
            y_d = yi - xs;
            z_d = zi + constant;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    logic [bitwidth-1:0] x_q;
    logic [bitwidth-1:0] y_q;
    logic [zwidth-1:0]   z_q;

    // Reset takes priority over the datapath on the same edge, so a reset
    // asserted mid-stream drops the in-flight sample completely.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // register samples values from before the edge, whatever the order of
        // the statements.
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end

    assign xo = x_q;
    assign yo = y_q;
    assign zo = z_q;

endmodule

// File: tb/tb_cordic_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_cordic_pipe_stage
//
// Five stages with shifts 0, 1, 2, 5 and 17 are driven from one shared input
// bus. A reference model computes the expected outputs with plain integer
// arithmetic: floor or half-up division by 2^k, followed by a reduction modulo
// the word width. On every clock, a compare process checks each stage against
// the model applied to the inputs and reset that were present at that edge.
// Hand-computed literal vectors pin the model itself.
// -----------------------------------------------------------------------------
module tb_cordic_pipe_stage;

    localparam int BW = 18;
    localparam int ZW = 15;
    localparam int NI = 5;

`ifdef CORDIC_STAGE_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] xi;
    logic [BW-1:0] yi;
    logic [ZW-1:0] zi;
    logic [ZW-1:0] constant;

    logic [BW-1:0] xo_a [NI];
    logic [BW-1:0] yo_a [NI];
    logic [ZW-1:0] zo_a [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic int shift_of(input int idx);
        case (idx)
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return 5;
            default: return 17;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            cordic_pipe_stage #(
                .bitwidth(BW),
                .zwidth  (ZW),
                .shift   (g == 0 ? 0 : g == 1 ? 1 : g == 2 ? 2 : g == 3 ? 5 : 17)
            ) u_dut (
                .clk     (clk),
                .reset   (reset),
                .xi      (xi),
                .yi      (yi),
                .zi      (zi),
                .constant(constant),
                .xo      (xo_a[g]),
                .yo      (yo_a[g]),
                .zo      (zo_a[g])
            );
        end
    endgenerate

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Divides by 2^k, rounding toward minus infinity. With rnd set, it first
    // adds half an LSB, which gives round half-up.
    function automatic longint scale(input longint v, input int k, input bit rnd);
        longint d;
        longint q;
        if (k == 0) return v;
        if (rnd) v = v + (64'sd1 <<< (k - 1));
        d = 64'sd1 <<< k;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    function automatic void model(
        input  logic [BW-1:0] x, input logic [BW-1:0] y,
        input  logic [ZW-1:0] z, input logic [ZW-1:0] c, input int k,
        output logic [BW-1:0] xe, output logic [BW-1:0] ye, output logic [ZW-1:0] ze);
        longint xv, yv, zv, cv, xsv, ysv, xr, yr, zr;
        xv  = longint'($signed(x));
        yv  = longint'($signed(y));
        zv  = longint'($signed(z));
        cv  = longint'(c);
        xsv = scale(xv, k, RND);
        ysv = scale(yv, k, RND);
        if (zv >= 0) begin
            xr = xv - ysv; yr = yv + xsv; zr = zv - cv;
        end else begin
            xr = xv + ysv; yr = yv - xsv; zr = zv + cv;
        end
        xe = xr[BW-1:0];
        ye = yr[BW-1:0];
        ze = zr[ZW-1:0];
    endfunction

    // Compare process: the model's result for the inputs seen at each edge
    // must appear on the outputs after that edge.
    logic [BW-1:0] xe_a [NI];
    logic [BW-1:0] ye_a [NI];
    logic [ZW-1:0] ze_a [NI];

    always begin
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                xe_a[i] = '0; ye_a[i] = '0; ze_a[i] = '0;
            end else begin
                model(xi, yi, zi, constant, shift_of(i), xe_a[i], ye_a[i], ze_a[i]);
            end
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("model_x[%0d]", i), longint'(xo_a[i]), longint'(xe_a[i]));
            check($sformatf("model_y[%0d]", i), longint'(yo_a[i]), longint'(ye_a[i]));
            check($sformatf("model_z[%0d]", i), longint'(zo_a[i]), longint'(ze_a[i]));
        end
    end

    task automatic drive(input logic [BW-1:0] x, input logic [BW-1:0] y,
                         input logic [ZW-1:0] z, input logic [ZW-1:0] c);
        xi = x; yi = y; zi = z; constant = c;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_xy();
        case ($urandom_range(0, 7))
            0:       return 18'h1FFFF;
            1:       return 18'h20000;
            2:       return '0;
            3:       return '1;
            default: return BW'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        drive(18'd1234, 18'd777, 15'd55, 15'd99);
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_x[%0d]", i), longint'(xo_a[i]), 0);
            check($sformatf("reset_y[%0d]", i), longint'(yo_a[i]), 0);
            check($sformatf("reset_z[%0d]", i), longint'(zo_a[i]), 0);
        end

        // Vector 1: shift 0, positive Z.
        reset = 1'b0;
        drive(18'd1000, 18'd500, 15'd100, 15'd8192);
        step();
        check("v1_x", longint'(xo_a[0]), 500);
        check("v1_y", longint'(yo_a[0]), 1500);
        check("v1_z", longint'(zo_a[0]), 24676);

        // Vector 2: shift 2, negative Z.
        drive(18'd1000, BW'(-400), ZW'(-100), 15'd2555);
        step();
        check("v2_x", longint'($signed(xo_a[2])), 900);
        check("v2_y", longint'($signed(yo_a[2])), -650);
        check("v2_z", longint'($signed(zo_a[2])), 2455);

        // Vector 3: wrap-around at the positive limit.
        drive(18'd131071, 18'd131071, 15'd0, 15'd1);
        step();
        check("v3_x", longint'(xo_a[0]), 0);
        check("v3_y", longint'(yo_a[0]), 262142);
        check("v3_z", longint'($signed(zo_a[0])), -1);

        // Vector 4: floor versus half-up on a negative odd value, shift 1.
        drive(18'd0, BW'(-5), 15'd0, 15'd0);
        step();
        check("v4_x", longint'(xo_a[1]), RND ? 2 : 3);

        // Back-to-back random stream. The compare process checks every cycle.
        for (int n = 0; n < 1000; n++) begin
            drive(rand_xy(), rand_xy(), ZW'($urandom), ZW'($urandom));
            step();
        end

        // Reset asserted mid-stream for a single edge.
        drive(rand_xy(), rand_xy(), ZW'($urandom), ZW'($urandom));
        reset = 1'b1;
        step();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("midreset_x[%0d]", i), longint'(xo_a[i]), 0);
            check($sformatf("midreset_y[%0d]", i), longint'(yo_a[i]), 0);
            check($sformatf("midreset_z[%0d]", i), longint'(zo_a[i]), 0);
        end
        reset = 1'b0;
        drive(18'd1000, 18'd500, 15'd100, 15'd8192);
        step();
        check("post_reset_x", longint'(xo_a[0]), 500);
        check("post_reset_y", longint'(yo_a[0]), 1500);
        check("post_reset_z", longint'(zo_a[0]), 24676);

        repeat (20) begin
            drive(rand_xy(), rand_xy(), ZW'($urandom), ZW'($urandom));
            step();
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
